gen_ready_param: RTL and testbench

GEN_READY_PARAM -- requirements
Module: gen_ready_param

---
 rtl/gen_ready_if.sv | 39 +++
 rtl/gen_ready_param.sv | 188 ++++++++++++++++++
 tb/tb_gen_ready_param.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_ready_if.sv
// Handshake and control bundle for gen_ready_param. The master side drives the
// frame/row strobes and the valid/ready inputs; the slave side is the pacing block.
interface gen_ready_if #(
  parameter int PIC_W = 6
);
  // Every valid/ready pair transfers exactly on a cycle where both are high at
  // the rising edge; valid and ready are independent and may rise in either order.
  logic             wr_sop;
  logic             wr_hsync;
  logic [PIC_W-1:0] pic_size;
  logic             padding;
  logic [3:0]       mode;
  logic             genraddr_end;
  logic             fifo_empty;
  logic             sram2reg_valid;
  logic             sram2reg_ready;
  logic             wr_valid;
  logic             wr_ready;
  logic             reg2opu_valid;
  logic             reg2opu_ready;
  logic             prime_row1;
  logic             busy;
  logic             frame_done;
  logic             overrun_err;

  modport master (
    output wr_sop, wr_hsync, pic_size, padding, mode, genraddr_end, fifo_empty,
           sram2reg_valid, wr_valid, reg2opu_ready,
    input  sram2reg_ready, wr_ready, reg2opu_valid, prime_row1, busy,
           frame_done, overrun_err
  );

  modport slave (
    input  wr_sop, wr_hsync, pic_size, padding, mode, genraddr_end, fifo_empty,
           sram2reg_valid, wr_valid, reg2opu_ready,
    output sram2reg_ready, wr_ready, reg2opu_valid, prime_row1, busy,
           frame_done, overrun_err
  );
endinterface

// File: rtl/gen_ready_param.sv
// Paces input-buffer writes against SRAM-to-register bank transfers, in a
// row-banked conv mode or a beat-counted dense mode.
module gen_ready_param #(
  parameter int PIC_W         = 6,
  parameter int PRIME_ROWS    = 4,
  parameter int ROWS_PER_BANK = 2,
  parameter int CNT_W         = 16,
  parameter int BEAT_SHIFT    = 3
) (
  input  logic       SYS_CLK,
  input  logic       SYS_RST,
  gen_ready_if.slave bus,
  output logic [2:0] dbg_state,
  output logic [7:0] dbg_row_cnt,
  output logic       dbg_gen_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    WAIT_XFER = 3'd2,
    FLUSH     = 3'd3,
    DENSE     = 3'd4
  } state_t;

  localparam int          ROW_CMP_W  = ((PIC_W > 8) ? PIC_W : 8) + 1;
  localparam logic [7:0]  PRIME_LAST = 8'(PRIME_ROWS - 1);
  localparam logic [7:0]  BANK_MASK  = 8'(ROWS_PER_BANK - 1);

  state_t           state_q, state_d;
  logic [7:0]       row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [PIC_W-1:0] pic_size_q, pic_size_d;
  logic             padding_q, padding_d;
  logic             gen_done_q, gen_done_d;
  logic             bank_done_q, bank_done_d;
  logic             overrun_q, overrun_d;
  logic             s2r_ready_q, s2r_ready_d;
  logic             wr_ready_q, wr_ready_d;
  logic             r2o_valid_q, r2o_valid_d;
  logic             frame_done_q, frame_done_d;

  logic                 s2r_hs, wr_hs, boundary, prime_ev, last_row;
  logic [ROW_CMP_W-1:0] last_tgt;
  logic [CNT_W-1:0]     beat_tgt;
  logic [7:0]           row_off;
  logic                 unused_mode;

  // mode[3] is captured by the DENSE/FILL choice at frame start; no other bit matters.
  assign unused_mode = ^bus.mode[2:0];

  assign s2r_hs   = bus.sram2reg_valid & s2r_ready_q;
  assign wr_hs    = bus.wr_valid & wr_ready_q;
  assign row_off  = row_cnt_q - PRIME_LAST;
  assign boundary = bus.wr_hsync & (row_cnt_q >= PRIME_LAST) & ((row_off & BANK_MASK) == 8'd0);
  assign prime_ev = boundary & (row_cnt_q == PRIME_LAST) & (state_q == FILL);
  assign last_tgt = ROW_CMP_W'(pic_size_q) + ROW_CMP_W'(padding_q);
  assign last_row = (ROW_CMP_W'(row_cnt_q) == last_tgt);
  assign beat_tgt = CNT_W'(pic_size_q) << BEAT_SHIFT;

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    pic_size_d   = pic_size_q;
    padding_d    = padding_q;
    gen_done_d   = gen_done_q;
    bank_done_d  = bank_done_q;
    overrun_d    = overrun_q;
    s2r_ready_d  = s2r_ready_q;
    wr_ready_d   = wr_ready_q;
    r2o_valid_d  = r2o_valid_q;
    frame_done_d = 1'b0;

    // Output-side valid runs on its own, independent of the frame state.
    if (r2o_valid_q && bus.reg2opu_ready) r2o_valid_d = 1'b0;
    else if (!bus.fifo_empty)             r2o_valid_d = 1'b1;

    if (bus.wr_sop) begin
      pic_size_d  = bus.pic_size;
      padding_d   = bus.padding;
      row_cnt_d   = 8'(bus.padding);
      beat_cnt_d  = '0;
      gen_done_d  = 1'b0;
      bank_done_d = 1'b0;
      overrun_d   = 1'b0;
      s2r_ready_d = 1'b0;
      wr_ready_d  = 1'b1;
      state_d     = bus.mode[3] ? DENSE : FILL;
    end else begin
      // A genraddr_end coinciding with a handshake belongs to the next bank.
      if (s2r_hs) gen_done_d = 1'b0;
      if (bus.genraddr_end && (state_q == FILL || state_q == WAIT_XFER || state_q == FLUSH))
        gen_done_d = 1'b1;

      case (state_q)
        FILL: begin
          if (bus.wr_hsync) row_cnt_d = row_cnt_q + 8'd1;
          if (last_row || boundary) begin
            state_d     = last_row ? FLUSH : WAIT_XFER;
            wr_ready_d  = 1'b0;
            bank_done_d = 1'b1;
          end
        end
        WAIT_XFER: begin
          if (bus.wr_hsync) begin
            row_cnt_d = row_cnt_q + 8'd1;
            overrun_d = 1'b1;
          end
          if (s2r_hs) begin
            wr_ready_d  = 1'b1;
            bank_done_d = 1'b0;
            state_d     = FILL;
          end
        end
        FLUSH: begin
          if (s2r_hs) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
        DENSE: begin
          if (wr_ready_q && (beat_cnt_q == beat_tgt)) begin
            wr_ready_d  = 1'b0;
            s2r_ready_d = 1'b1;
            beat_cnt_d  = '0;
          end else if (wr_hs) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
          if (s2r_hs) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
        IDLE:    ;
        default: state_d = IDLE;
      endcase

      if (bus.fifo_empty && (prime_ev ||
          ((state_q == WAIT_XFER || state_q == FLUSH) && bank_done_q && gen_done_q)))
        s2r_ready_d = 1'b1;
      if (s2r_hs) s2r_ready_d = 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      pic_size_q   <= '0;
      padding_q    <= 1'b0;
      gen_done_q   <= 1'b0;
      bank_done_q  <= 1'b0;
      overrun_q    <= 1'b0;
      s2r_ready_q  <= 1'b0;
      wr_ready_q   <= 1'b0;
      r2o_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      pic_size_q   <= pic_size_d;
      padding_q    <= padding_d;
      gen_done_q   <= gen_done_d;
      bank_done_q  <= bank_done_d;
      overrun_q    <= overrun_d;
      s2r_ready_q  <= s2r_ready_d;
      wr_ready_q   <= wr_ready_d;
      r2o_valid_q  <= r2o_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sram2reg_ready = s2r_ready_q;
  assign bus.wr_ready       = wr_ready_q;
  assign bus.reg2opu_valid  = r2o_valid_q;
  assign bus.prime_row1     = bus.wr_hsync & (row_cnt_q == 8'd1);
  assign bus.busy           = (state_q != IDLE);
  assign bus.frame_done     = frame_done_q;
  assign bus.overrun_err    = overrun_q;

  assign dbg_state    = state_q;
  assign dbg_row_cnt  = row_cnt_q;
  assign dbg_gen_done = gen_done_q;

endmodule

// File: tb/tb_gen_ready_param.sv
// Directed bench for gen_ready_param: reset, conv priming and bank gating,
// overrun/restart, coincident frame end, dense mode and mid-frame reset.
module tb_gen_ready_param;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DENSE = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  logic [7:0] dbg_row_cnt;
  logic       dbg_gen_done;
  int         n_checks = 0;
  int         n_pass   = 0;

  gen_ready_if #(.PIC_W(6)) bus ();

  gen_ready_param #(
    .PIC_W(6), .PRIME_ROWS(4), .ROWS_PER_BANK(2), .CNT_W(16), .BEAT_SHIFT(3)
  ) dut (
    .SYS_CLK     (clk),
    .SYS_RST     (rst),
    .bus         (bus),
    .dbg_state   (dbg_state),
    .dbg_row_cnt (dbg_row_cnt),
    .dbg_gen_done(dbg_gen_done)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- driver tasks ----
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic expect_st(input string tag, input logic wr_r, input logic s2r_r, input logic [2:0] st);
    check({tag, "/wr_ready"}, 32'(bus.wr_ready), 32'(wr_r));
    check({tag, "/s2r_ready"}, 32'(bus.sram2reg_ready), 32'(s2r_r));
    check({tag, "/state"}, 32'(dbg_state), 32'(st));
  endtask

  task automatic hsync();
    bus.wr_hsync = 1'b1;
    cyc();
    bus.wr_hsync = 1'b0;
  endtask

  task automatic s2r_handshake();
    bus.sram2reg_valid = 1'b1;
    cyc();
    bus.sram2reg_valid = 1'b0;
  endtask

  task automatic gen_end();
    bus.genraddr_end = 1'b1;
    cyc();
    bus.genraddr_end = 1'b0;
  endtask

  // Frame start; the inputs are scrambled afterwards so only latched values can be used.
  task automatic start(input logic [5:0] ps, input logic pad, input logic [3:0] md);
    bus.pic_size = ps;
    bus.padding  = pad;
    bus.mode     = md;
    bus.wr_sop   = 1'b1;
    cyc();
    bus.wr_sop   = 1'b0;
    bus.pic_size = ~ps;
    bus.padding  = ~pad;
    bus.mode     = 4'b0111;
  endtask

  // ---- stimulus and checks ----
  initial begin
    bus.wr_sop = 0; bus.wr_hsync = 0; bus.pic_size = 0; bus.padding = 0; bus.mode = 0;
    bus.genraddr_end = 0; bus.fifo_empty = 1; bus.sram2reg_valid = 0;
    bus.wr_valid = 0; bus.reg2opu_ready = 0;

    // reset
    cyc(); cyc();
    expect_st("rst", 0, 0, ST_IDLE);
    check("rst/busy", 32'(bus.busy), 0);
    check("rst/reg2opu_valid", 32'(bus.reg2opu_valid), 0);
    check("rst/frame_done", 32'(bus.frame_done), 0);
    check("rst/overrun", 32'(bus.overrun_err), 0);
    rst = 1'b0;
    cyc();

    // conv priming: pic 8, pad 0
    start(6'd8, 1'b0, 4'b0000);
    expect_st("sop", 1, 0, ST_FILL);
    check("sop/busy", 32'(bus.busy), 1);
    check("sop/row", 32'(dbg_row_cnt), 0);
    hsync();
    bus.wr_hsync = 1'b1;
    #1;
    check("prime_row1", 32'(bus.prime_row1), 1);
    cyc();
    bus.wr_hsync = 1'b0;
    check("prime_row1_low", 32'(bus.prime_row1), 0);
    hsync();
    expect_st("pre_prime", 1, 0, ST_FILL);
    hsync();
    expect_st("prime", 0, 1, ST_WAIT);
    check("prime/row", 32'(dbg_row_cnt), 4);
    s2r_handshake();
    expect_st("prime_hs", 1, 0, ST_FILL);

    // bank gating at row 5
    hsync(); hsync();
    expect_st("bank2", 0, 0, ST_WAIT);
    cyc(); cyc();
    expect_st("bank2_nogen", 0, 0, ST_WAIT);
    bus.fifo_empty = 1'b0;
    gen_end();
    check("gen_done_set", 32'(dbg_gen_done), 1);
    check("r2o_set", 32'(bus.reg2opu_valid), 1);
    check("bank2_fifo_busy", 32'(bus.sram2reg_ready), 0);
    bus.reg2opu_ready = 1'b1;
    cyc();
    check("r2o_clear_wins", 32'(bus.reg2opu_valid), 0);
    bus.reg2opu_ready = 1'b0;
    cyc();
    check("r2o_reset", 32'(bus.reg2opu_valid), 1);
    check("bank2_fifo_busy2", 32'(bus.sram2reg_ready), 0);
    bus.fifo_empty = 1'b1;
    cyc();
    expect_st("bank2_ready", 0, 1, ST_WAIT);
    s2r_handshake();
    expect_st("bank2_hs", 1, 0, ST_FILL);
    check("bank2_gen_clr", 32'(dbg_gen_done), 0);
    bus.reg2opu_ready = 1'b1;
    cyc();
    bus.reg2opu_ready = 1'b0;
    check("r2o_drain", 32'(bus.reg2opu_valid), 0);

    // overrun then restart with padding
    hsync(); hsync();
    expect_st("bank3", 0, 0, ST_WAIT);
    hsync();
    check("overrun", 32'(bus.overrun_err), 1);
    check("overrun/row", 32'(dbg_row_cnt), 9);
    start(6'd8, 1'b1, 4'b0000);
    check("restart/overrun", 32'(bus.overrun_err), 0);
    check("restart/row", 32'(dbg_row_cnt), 1);
    expect_st("restart", 1, 0, ST_FILL);

    // frame end with coincident events: pic 8, pad 1
    hsync(); hsync(); hsync();
    expect_st("p1_prime", 0, 1, ST_WAIT);
    s2r_handshake();
    hsync(); hsync();
    expect_st("p1_bank2", 0, 0, ST_WAIT);
    gen_end(); cyc();
    check("p1_bank2_ready", 32'(bus.sram2reg_ready), 1);
    s2r_handshake();
    hsync(); hsync();
    gen_end(); cyc(); s2r_handshake();
    expect_st("p1_bank3_hs", 1, 0, ST_FILL);
    check("p1_row8", 32'(dbg_row_cnt), 8);
    hsync();
    expect_st("p1_row9", 1, 0, ST_FILL);
    cyc();
    expect_st("flush", 0, 0, ST_FLUSH);
    gen_end(); cyc();
    expect_st("flush_ready", 0, 1, ST_FLUSH);
    bus.sram2reg_valid = 1'b1;
    bus.genraddr_end   = 1'b1;
    cyc();
    bus.sram2reg_valid = 1'b0;
    bus.genraddr_end   = 1'b0;
    check("flush/frame_done", 32'(bus.frame_done), 1);
    check("flush/busy", 32'(bus.busy), 0);
    check("flush/gen_done", 32'(dbg_gen_done), 1);
    expect_st("flush_hs", 0, 0, ST_IDLE);
    cyc();
    check("frame_done_pulse", 32'(bus.frame_done), 0);

    // idle ignores strobes
    bus.wr_hsync = 1'b1; bus.sram2reg_valid = 1'b1; bus.wr_valid = 1'b1;
    cyc();
    bus.wr_hsync = 1'b0; bus.sram2reg_valid = 1'b0; bus.wr_valid = 1'b0;
    expect_st("idle", 0, 0, ST_IDLE);
    check("idle/row", 32'(dbg_row_cnt), 9);
    check("idle/frame_done", 32'(bus.frame_done), 0);

    // dense: pic 2 -> 16 beats
    start(6'd2, 1'b0, 4'b1000);
    expect_st("dense_sop", 1, 0, ST_DENSE);
    for (int i = 0; i < 16; i++) begin
      bus.wr_valid     = 1'b1;
      bus.wr_hsync     = (i % 5 == 0);
      bus.genraddr_end = (i == 3);
      cyc();
    end
    bus.wr_valid = 1'b0; bus.wr_hsync = 1'b0; bus.genraddr_end = 1'b0;
    expect_st("dense_16", 1, 0, ST_DENSE);
    check("dense/row", 32'(dbg_row_cnt), 0);
    check("dense/gen_done", 32'(dbg_gen_done), 0);
    cyc();
    expect_st("dense_full", 0, 1, ST_DENSE);
    s2r_handshake();
    check("dense/frame_done", 32'(bus.frame_done), 1);
    expect_st("dense_end", 0, 0, ST_IDLE);

    // dense pic 0 ends on the first cycle
    start(6'd0, 1'b0, 4'b1000);
    expect_st("dense0_sop", 1, 0, ST_DENSE);
    bus.fifo_empty = 1'b0;
    cyc();
    expect_st("dense0_full", 0, 1, ST_DENSE);
    check("dense0/r2o", 32'(bus.reg2opu_valid), 1);

    // reset mid-dense
    rst = 1'b1;
    cyc(); cyc();
    bus.fifo_empty = 1'b1;
    rst = 1'b0;
    expect_st("midrst", 0, 0, ST_IDLE);
    check("midrst/busy", 32'(bus.busy), 0);
    check("midrst/r2o", 32'(bus.reg2opu_valid), 0);
    check("midrst/frame_done", 32'(bus.frame_done), 0);
    bus.wr_valid = 1'b1;
    cyc();
    bus.wr_valid = 1'b0;
    check("midrst/wr_valid", 32'(bus.wr_ready), 0);

    // reset beats a simultaneous sop
    rst = 1'b1; bus.wr_sop = 1'b1;
    cyc();
    rst = 1'b0; bus.wr_sop = 1'b0;
    check("rst_sop/busy", 32'(bus.busy), 0);
    cyc();
    expect_st("rst_sop", 0, 0, ST_IDLE);

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
